ptr_release_mgr: RTL and testbench
==================================

Name: ptr_release_mgr

Overview:
- Return side of the free-pointer queue. Holds a per-buffer reference count for every 10-bit buffer pointer.
- The write path loads the count when a frame is stored. Each output port releases the pointer after transmitting; on the last release the block pushes the pointer back to the free queue (FQ_wr / ptr_dout).
- Multicast frames share one buffer: the count equals the number of destination ports.

Parameters:
- PORTS, 4, number of output ports issuing releases
- PTR_W, 10, pointer width
- DEPTH, 512, number of buffer pointers (2^(PTR_W-1)); pointers are 0..DEPTH-1
- CNT_W, 4, reference count width; must hold PORTS

Ports:
- clk  in  1  single clock
- rstn  in  1  reset; asynchronous, active-high (asserted = 1), despite the name
- set_req  in  1  write path loads a count this cycle
- set_ptr  in  PTR_W  pointer being loaded
- set_cnt  in  CNT_W  number of destinations; 0 = drop frame
- rel_req  in  PORTS  per-port release request; held until acked
- rel_ptr  in  PORTS*PTR_W  per-port pointer; port i uses bits [i*PTR_W +: PTR_W]
- rel_ack  out  PORTS  one-hot, combinational; high in the cycle a port's release is consumed
- FQ_wr  out  1  registered one-cycle push strobe to the free queue
- ptr_dout  out  16  pointer returned to the free queue; bits [15:PTR_W] = 0
- err_pulse  out  1  registered one-cycle protocol-error flag

Behaviour:
- Reset (async, rstn=1):
  - all DEPTH counts = 0
  - FQ_wr = 0, ptr_dout = 0, err_pulse = 0
  - round-robin last-grant = PORTS-1, so port 0 wins first
- One operation per cycle. Set has absolute priority over releases.
- Set cycle (set_req=1):
  - count[set_ptr] <= set_cnt at the clock edge
  - rel_ack = 0 for all ports; requesters keep their requests held
  - If set_cnt==0: FQ_wr=1 and ptr_dout=set_ptr in the next cycle
  - If the old count[set_ptr] != 0: the count is still overwritten, and err_pulse=1 in the next cycle
- Release cycle (set_req=0, any rel_req bit set):
  - Round-robin grant: first requesting port after the last-granted index, wrapping PORTS-1 -> 0.
  - rel_ack[g]=1 in the same cycle; last-grant <= g.
  - If count[p] > 1 (p = rel_ptr[g]): count[p] <= count[p]-1, no push.
  - If count[p] == 1: count[p] <= 0; FQ_wr=1 and ptr_dout=p in the next cycle.
  - If count[p] == 0 (underflow): count stays 0, no push, err_pulse=1 next cycle; the request is still acked.
- Latency: the decision is taken in cycle N; FQ_wr/ptr_dout are registered and valid in cycle N+1. Because at most one operation runs per cycle, at most one push occurs per cycle.
- The count update is a same-cycle read-modify-write on a flop array, so back-to-back operations on the same pointer see the updated value with no hazard.
- Two ports releasing the same pointer are serialized across cycles; each decrements once.
- rel_ptr values >= DEPTH cannot occur when PTR_W = log2(DEPTH); the upper bit is ignored.
- FQ_wr is never held. The free queue accepts unconditionally because its depth equals DEPTH.
- A reset asserted mid-operation clears everything immediately. Pointers in flight are lost; the free queue re-initialises alongside this block.

Decomposition:
- Shared package: PTR_W, DEPTH, CNT_W, PORTS defaults; the 16-bit pointer-bus width constant; a function extracting the port-i slice of rel_ptr.
- One sub-module, rr_arbiter: PORTS-wide request vector and enable in, one-hot grant out, last-grant state inside. The parent drives enable = !set_req.

Test Plan:
- set ptr 0x005 cnt 3, then releases of 0x005 from ports 0,1,2 in separate cycles -> the first two acked with no push; FQ_wr=1 with ptr_dout=0x0005 exactly one cycle after the third ack.
- Ports 0-3 request together on ptrs 0x010-0x013 (each cnt 1) -> rel_ack 0001, 0010, 0100, 1000 in consecutive cycles; FQ_wr in four consecutive cycles with 0x0010..0x0013.
- set ptr 0x1FF cnt 0 -> FQ_wr=1, ptr_dout=0x01FF next cycle; count stays 0.
- Release of ptr 0x020 with count 0 -> rel_ack pulses; err_pulse=1 next cycle; FQ_wr stays 0.
- set_req on 0x030 cnt 2 while port 1 requests 0x030 -> no ack that cycle; ack the next cycle; count=1; no push.
- rstn=1 mid-sequence with count[0x005]=2 -> outputs 0 immediately; after release, a release of 0x005 produces err_pulse and no push.

Source files
------------

// File: rtl/ptr_release_mgr_pkg.sv
// Shared constants and helpers for the free-pointer return path.
// Module parameters default to these values.
package ptr_release_mgr_pkg;

  localparam int PORTS_DEF = 4;
  localparam int PTR_W_DEF = 10;
  localparam int DEPTH_DEF = 512;
  localparam int CNT_W_DEF = 4;
  localparam int BUS_W     = 16;

  // Port i's pointer slice of the packed per-port release-pointer bus.
  function automatic logic [PTR_W_DEF-1:0] port_ptr(
    input logic [PORTS_DEF*PTR_W_DEF-1:0] bus,
    input int                             i
  );
    return bus[i*PTR_W_DEF +: PTR_W_DEF];
  endfunction

endpackage

// File: rtl/ptr_release_mgr_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
// The last-winner index resets to PORTS-1, so port 0 wins first.
module rr_arbiter #(
  parameter int PORTS = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [PORTS-1:0] req,
  input  logic             en,
  output logic [PORTS-1:0] grant
);

  localparam int LG_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [LG_W-1:0] last_grant;
  logic [LG_W-1:0] grant_idx;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      int idx;
      idx = (int'(last_grant) + k) % PORTS;
      if (!found && en && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = LG_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      last_grant <= LG_W'(PORTS - 1);
    end else if (found) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/ptr_release_mgr.sv
// Per-buffer reference counts. A write-path set loads a count.
// Port releases decrement it; the last release pushes the pointer back to the free queue.
module ptr_release_mgr
  import ptr_release_mgr_pkg::*;
#(
  parameter int PORTS = PORTS_DEF,
  parameter int PTR_W = PTR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               set_req,
  input  logic [PTR_W-1:0]   set_ptr,
  input  logic [CNT_W-1:0]   set_cnt,
  input  logic [PORTS-1:0]   rel_req,
  input  logic [PORTS*PTR_W-1:0] rel_ptr,
  output logic [PORTS-1:0]   rel_ack,
  output logic               FQ_wr,
  output logic [BUS_W-1:0]   ptr_dout,
  output logic               err_pulse
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0] cnt_mem [DEPTH];
  logic [PORTS-1:0] grant;
  logic [PTR_W-1:0] sel_ptr;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] set_idx;
  logic [CNT_W-1:0] sel_cnt;
  logic [CNT_W-1:0] set_old_cnt;

  // Sets take the whole cycle, so the arbiter is disabled and requesters wait.
  rr_arbiter #(.PORTS(PORTS)) u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .req   (rel_req),
    .en    (!set_req),
    .grant (grant)
  );

  assign rel_ack = grant;

  always_comb begin
    sel_ptr = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant[i]) sel_ptr = port_ptr(rel_ptr, i);
    end
  end

  // The pointer MSB lies beyond DEPTH and never indexes the count array.
  assign sel_idx     = sel_ptr[IDX_W-1:0];
  assign set_idx     = set_ptr[IDX_W-1:0];
  assign sel_cnt     = cnt_mem[sel_idx];
  assign set_old_cnt = cnt_mem[set_idx];

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int j = 0; j < DEPTH; j++) cnt_mem[j] <= '0;
      FQ_wr     <= 1'b0;
      ptr_dout  <= '0;
      err_pulse <= 1'b0;
    end else begin
      FQ_wr     <= 1'b0;
      err_pulse <= 1'b0;
      if (set_req) begin
        cnt_mem[set_idx] <= set_cnt;
        if (set_cnt == '0) begin
          FQ_wr    <= 1'b1;
          ptr_dout <= BUS_W'(set_ptr);
        end
        if (set_old_cnt != '0) err_pulse <= 1'b1;
      end else if (|grant) begin
        if (sel_cnt == '0) begin
          err_pulse <= 1'b1;
        end else begin
          cnt_mem[sel_idx] <= sel_cnt - CNT_W'(1);
          if (sel_cnt == CNT_W'(1)) begin
            FQ_wr    <= 1'b1;
            ptr_dout <= BUS_W'(sel_ptr);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ptr_release_mgr.sv
// Directed vector bench for ptr_release_mgr: table of single-cycle operations
// plus a hand-written asynchronous reset sequence.
module tb_ptr_release_mgr;

  localparam int PORTS = 4;
  localparam int PTR_W = 10;
  localparam int CNT_W = 4;

  typedef struct {
    string              name;
    logic               set_req;
    logic [PTR_W-1:0]   set_ptr;
    logic [CNT_W-1:0]   set_cnt;
    logic [PORTS-1:0]   rel_req;
    logic [PORTS*PTR_W-1:0] rel_ptr;
    logic [PORTS-1:0]   exp_ack;
    logic               exp_fq;
    logic [15:0]        exp_dout;
    logic               exp_err;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   set_req;
  logic [PTR_W-1:0]       set_ptr;
  logic [CNT_W-1:0]       set_cnt;
  logic [PORTS-1:0]       rel_req;
  logic [PORTS*PTR_W-1:0] rel_ptr;
  logic [PORTS-1:0]       rel_ack;
  logic                   FQ_wr;
  logic [15:0]            ptr_dout;
  logic                   err_pulse;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  ptr_release_mgr dut (
    .clk       (clk),
    .rstn      (rstn),
    .set_req   (set_req),
    .set_ptr   (set_ptr),
    .set_cnt   (set_cnt),
    .rel_req   (rel_req),
    .rel_ptr   (rel_ptr),
    .rel_ack   (rel_ack),
    .FQ_wr     (FQ_wr),
    .ptr_dout  (ptr_dout),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [PORTS*PTR_W-1:0] pk(input logic [PTR_W-1:0] p0, p1, p2, p3);
    return {p3, p2, p1, p0};
  endfunction

  function automatic vec_t mk(input string name, input logic sr, input logic [PTR_W-1:0] sp,
                              input logic [CNT_W-1:0] sc, input logic [PORTS-1:0] rr,
                              input logic [PORTS*PTR_W-1:0] rp, input logic [PORTS-1:0] ack,
                              input logic fq, input logic [15:0] dout, input logic err);
    vec_t v;
    v.name = name; v.set_req = sr; v.set_ptr = sp; v.set_cnt = sc;
    v.rel_req = rr; v.rel_ptr = rp; v.exp_ack = ack;
    v.exp_fq = fq; v.exp_dout = dout; v.exp_err = err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle: check the combinational ack before the edge, registered outputs after it.
  task automatic applyStimulus(input vec_t v);
    set_req = v.set_req;
    set_ptr = v.set_ptr;
    set_cnt = v.set_cnt;
    rel_req = v.rel_req;
    rel_ptr = v.rel_ptr;
    #4;
    checkOutput({v.name, " rel_ack"}, 32'(rel_ack), 32'(v.exp_ack));
    @(posedge clk);
    #1;
    set_req = 1'b0;
    rel_req = '0;
    checkOutput({v.name, " FQ_wr"}, 32'(FQ_wr), 32'(v.exp_fq));
    checkOutput({v.name, " err_pulse"}, 32'(err_pulse), 32'(v.exp_err));
    if (v.exp_fq) checkOutput({v.name, " ptr_dout"}, 32'(ptr_dout), 32'(v.exp_dout));
  endtask

  initial begin
    rstn = 1'b1; set_req = 1'b0; set_ptr = '0; set_cnt = '0; rel_req = '0; rel_ptr = '0;

    // Three-way multicast, then a port-3 release to move the round-robin pointer.
    vecs.push_back(mk("set005c3",  1, 10'h005, 3, 4'b0000, pk(0,0,0,0), 4'b0000, 0, 16'h0, 0));
    vecs.push_back(mk("rel005p0",  0, 0, 0, 4'b0001, pk(10'h005,0,0,0), 4'b0001, 0, 16'h0, 0));
    vecs.push_back(mk("rel005p1",  0, 0, 0, 4'b0010, pk(0,10'h005,0,0), 4'b0010, 0, 16'h0, 0));
    vecs.push_back(mk("rel005p2",  0, 0, 0, 4'b0100, pk(0,0,10'h005,0), 4'b0100, 1, 16'h0005, 0));
    vecs.push_back(mk("set040c1",  1, 10'h040, 1, 4'b0000, pk(0,0,0,0), 4'b0000, 0, 16'h0, 0));
    vecs.push_back(mk("rel040p3",  0, 0, 0, 4'b1000, pk(0,0,0,10'h040), 4'b1000, 1, 16'h0040, 0));
    // Four ports contending on unicast pointers.
    vecs.push_back(mk("set010",    1, 10'h010, 1, 4'b0000, pk(0,0,0,0), 4'b0000, 0, 16'h0, 0));
    vecs.push_back(mk("set011",    1, 10'h011, 1, 4'b0000, pk(0,0,0,0), 4'b0000, 0, 16'h0, 0));
    vecs.push_back(mk("set012",    1, 10'h012, 1, 4'b0000, pk(0,0,0,0), 4'b0000, 0, 16'h0, 0));
    vecs.push_back(mk("set013",    1, 10'h013, 1, 4'b0000, pk(0,0,0,0), 4'b0000, 0, 16'h0, 0));
    vecs.push_back(mk("rr0", 0, 0, 0, 4'b1111, pk(10'h010,10'h011,10'h012,10'h013), 4'b0001, 1, 16'h0010, 0));
    vecs.push_back(mk("rr1", 0, 0, 0, 4'b1110, pk(10'h010,10'h011,10'h012,10'h013), 4'b0010, 1, 16'h0011, 0));
    vecs.push_back(mk("rr2", 0, 0, 0, 4'b1100, pk(10'h010,10'h011,10'h012,10'h013), 4'b0100, 1, 16'h0012, 0));
    vecs.push_back(mk("rr3", 0, 0, 0, 4'b1000, pk(10'h010,10'h011,10'h012,10'h013), 4'b1000, 1, 16'h0013, 0));
    // Drop frame, then underflow on the dropped and a never-set pointer.
    vecs.push_back(mk("set1FFc0",  1, 10'h1FF, 0, 4'b0000, pk(0,0,0,0), 4'b0000, 1, 16'h01FF, 0));
    vecs.push_back(mk("rel1FFuf",  0, 0, 0, 4'b0001, pk(10'h1FF,0,0,0), 4'b0001, 0, 16'h0, 1));
    vecs.push_back(mk("rel020uf",  0, 0, 0, 4'b0010, pk(0,10'h020,0,0), 4'b0010, 0, 16'h0, 1));
    // Set blocks a same-cycle release; the held request is served afterwards.
    vecs.push_back(mk("set030blk", 1, 10'h030, 2, 4'b0010, pk(0,10'h030,0,0), 4'b0000, 0, 16'h0, 0));
    vecs.push_back(mk("rel030p1",  0, 0, 0, 4'b0010, pk(0,10'h030,0,0), 4'b0010, 0, 16'h0, 0));
    vecs.push_back(mk("rel030p2",  0, 0, 0, 4'b0100, pk(0,0,10'h030,0), 4'b0100, 1, 16'h0030, 0));
    // Overwriting a live count flags an error.
    vecs.push_back(mk("set031c1",  1, 10'h031, 1, 4'b0000, pk(0,0,0,0), 4'b0000, 0, 16'h0, 0));
    vecs.push_back(mk("set031ovr", 1, 10'h031, 2, 4'b0000, pk(0,0,0,0), 4'b0000, 0, 16'h0, 1));
    vecs.push_back(mk("set005c2",  1, 10'h005, 2, 4'b0000, pk(0,0,0,0), 4'b0000, 0, 16'h0, 0));
    vecs.push_back(mk("set050c0",  1, 10'h050, 0, 4'b0000, pk(0,0,0,0), 4'b0000, 1, 16'h0050, 0));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset FQ_wr", 32'(FQ_wr), 32'd0);
    checkOutput("reset ptr_dout", 32'(ptr_dout), 32'd0);
    checkOutput("reset err_pulse", 32'(err_pulse), 32'd0);
    checkOutput("reset rel_ack", 32'(rel_ack), 32'd0);
    rstn = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Asynchronous reset while FQ_wr is high clears outputs without a clock edge.
    #2;
    rstn = 1'b1;
    #1;
    checkOutput("midrst FQ_wr", 32'(FQ_wr), 32'd0);
    checkOutput("midrst ptr_dout", 32'(ptr_dout), 32'd0);
    checkOutput("midrst err_pulse", 32'(err_pulse), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(mk("postrst005", 0, 0, 0, 4'b0001, pk(10'h005,0,0,0), 4'b0001, 0, 16'h0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
